// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
// Hole count, hit encodings, round state and hole index helper.
package mole_pkg;

  localparam int NUM_HOLES = 5;

  localparam logic [2:0] HIT_NONE = 3'd0;
  localparam logic [2:0] HIT_H0   = 3'd1;
  localparam logic [2:0] HIT_H1   = 3'd2;
  localparam logic [2:0] HIT_H2   = 3'd3;
  localparam logic [2:0] HIT_H3   = 3'd4;
  localparam logic [2:0] HIT_H4   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_OVER
  } game_state_t;

  // Low three random bits folded onto the five holes (5,6,7 -> 0,1,2).
  function automatic logic [2:0] hole_of(input logic [7:0] r);
    return (r[2:0] > 3'd4) ? r[2:0] - 3'd5 : r[2:0];
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Game control bus: start/hit commands in, mole bitmap,
// counters and round status out.
interface mole_scheduler_if
  import mole_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic                 start;
  logic [2:0]           hit;
  logic [NUM_HOLES-1:0] moles;
  logic [CNT_W-1:0]     score;
  logic [CNT_W-1:0]     misses;
  logic [CNT_W-1:0]     escapes;
  logic                 game_active;
  logic                 game_over;

  modport master (
    output start, hit,
    input  moles, score, misses, escapes,
    input  game_active, game_over
  );

  modport slave (
    input  start, hit,
    output moles, score, misses, escapes,
    output game_active, game_over
  );

endinterface

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1,
// seeded with 8'hA5 on reset.
module mole_lfsr (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] lfsr
);

  logic fb;

  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], fb};
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round controller: spawns, ages and scores moles.
// Optional MOLE_SPEEDUP_EN shortens the spawn interval every 8 hits.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int SPAWN_INTERVAL = 50000000,
  parameter int MIN_INTERVAL   = 10000000,
  parameter int MOLE_LIFE      = 75000000,
  parameter int GAME_CYCLES    = 1500000000,
  parameter int CNT_W          = 8
) (
  input  logic            clock,
  input  logic            reset,
  mole_scheduler_if.slave bus
);

  localparam int TW = $clog2(GAME_CYCLES + 1);
  localparam int LW = $clog2(MOLE_LIFE + 1);
  localparam int IMAX = (SPAWN_INTERVAL > MIN_INTERVAL) ?
                        SPAWN_INTERVAL : MIN_INTERVAL;
  localparam int IW = $clog2(IMAX + 1);

  game_state_t state_q, state_d;

  logic [TW-1:0]        timer_q, timer_d;
  logic [IW-1:0]        spawn_q, spawn_d;
  logic [LW-1:0]        life_q [NUM_HOLES];
  logic [LW-1:0]        life_d [NUM_HOLES];
  logic [NUM_HOLES-1:0] moles_q, moles_d;
  logic [CNT_W-1:0]     score_q, score_d;
  logic [CNT_W-1:0]     miss_q, miss_d;
  logic [CNT_W-1:0]     esc_q, esc_d;
  logic                 act_q, act_d;
  logic                 over_q, over_d;
  logic [7:0]           lfsr;
  logic [2:0]           idx;
  logic                 hit_vld;
  logic [IW-1:0]        interval;

  mole_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign idx = hole_of(lfsr);

`ifdef MOLE_SPEEDUP_EN
  logic [IW-1:0] interval_d;
  logic [IW-1:0] shrunk;

  assign shrunk = interval - (interval >> 3);

  always_ff @(posedge clock) begin
    if (reset) interval <= IW'(SPAWN_INTERVAL);
    else       interval <= interval_d;
  end
`else
  assign interval = IW'(SPAWN_INTERVAL);
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    spawn_d = spawn_q;
    life_d  = life_q;
    moles_d = moles_q;
    score_d = score_q;
    miss_d  = miss_q;
    esc_d   = esc_q;
    hit_vld = bus.hit inside {[HIT_H0:HIT_H4]};
`ifdef MOLE_SPEEDUP_EN
    interval_d = interval;
`endif
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d = ST_PLAY;
          timer_d = TW'(GAME_CYCLES - 1);
          spawn_d = IW'(SPAWN_INTERVAL - 1);
          moles_d = '0;
          score_d = '0;
          miss_d  = '0;
          esc_d   = '0;
`ifdef MOLE_SPEEDUP_EN
          interval_d = IW'(SPAWN_INTERVAL);
`endif
        end
      end
      ST_PLAY: begin
        if (timer_q == '0) begin
          state_d = ST_OVER;
          moles_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
          spawn_d = spawn_q - 1'b1;
          // Hit is judged on the pre-edge bitmap and beats expiry.
          for (int i = 0; i < NUM_HOLES; i++) begin
            if (moles_q[i]) begin
              life_d[i] = life_q[i] - 1'b1;
              if (hit_vld && bus.hit == 3'(i + 1)) begin
                moles_d[i] = 1'b0;
                if (!(&score_d)) score_d = score_d + 1'b1;
              end else if (life_q[i] == '0) begin
                moles_d[i] = 1'b0;
                if (!(&esc_d)) esc_d = esc_d + 1'b1;
              end
            end else if (hit_vld && bus.hit == 3'(i + 1)) begin
              if (!(&miss_d)) miss_d = miss_d + 1'b1;
            end
          end
          if (spawn_q == '0) begin
            spawn_d = interval - 1'b1;
            if (!moles_q[idx]) begin
              moles_d[idx] = 1'b1;
              life_d[idx]  = LW'(MOLE_LIFE - 1);
            end
          end
`ifdef MOLE_SPEEDUP_EN
          if (score_d != score_q && score_d[2:0] == 3'd0)
            interval_d = (shrunk < IW'(MIN_INTERVAL)) ?
                         IW'(MIN_INTERVAL) : shrunk;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    act_d  = (state_d == ST_PLAY);
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
      spawn_q <= '0;
      moles_q <= '0;
      score_q <= '0;
      miss_q  <= '0;
      esc_q   <= '0;
      act_q   <= 1'b0;
      over_q  <= 1'b0;
      for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= '0;
    end else begin
      timer_q <= timer_d;
      spawn_q <= spawn_d;
      moles_q <= moles_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      esc_q   <= esc_d;
      act_q   <= act_d;
      over_q  <= over_d;
      life_q  <= life_d;
    end
  end

  assign bus.moles       = moles_q;
  assign bus.score       = score_q;
  assign bus.misses      = miss_q;
  assign bus.escapes     = esc_q;
  assign bus.game_active = act_q;
  assign bus.game_over   = over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler against an event-time
// reference model of the round (small timing parameters).
module tb_mole_scheduler;

  localparam int SI = 4;
  localparam int MI = 2;
  localparam int ML = 6;
  localparam int GC = 64;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mole_scheduler_if #(.CNT_W(CW)) ifc ();

  mole_scheduler #(
    .SPAWN_INTERVAL (SI),
    .MIN_INTERVAL   (MI),
    .MOLE_LIFE      (ML),
    .GAME_CYCLES    (GC),
    .CNT_W          (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 idle, 1 play, 2 over; times are edges since round start.
  int       m_state;
  int       k;
  bit [4:0] m_up;
  int       m_exp [5];
  int       m_next_spawn;
  int       m_interval;
  int       m_score, m_miss, m_esc;
  bit [7:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic bit [7:0] lfsr_step(input bit [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic model_edge(input bit s, input int h, input bit r);
    bit [7:0] pre_lfsr;
    bit [4:0] pre;
    bit       sp;
    int       idx;
    pre_lfsr = m_lfsr;
    m_lfsr   = lfsr_step(m_lfsr);
    if (r) begin
      m_state = 0; m_up = '0;
      m_score = 0; m_miss = 0; m_esc = 0;
      m_interval = SI;
      m_lfsr = 8'hA5;
      return;
    end
    if (m_state != 1) begin
      if (s) begin
        m_state = 1; k = 0; m_up = '0;
        m_score = 0; m_miss = 0; m_esc = 0;
        m_interval = SI; m_next_spawn = SI;
      end
      return;
    end
    k++;
    if (k == GC) begin
      m_state = 2;
      m_up = '0;
      return;
    end
    pre = m_up;
    sp  = 1'b0;
    if (h >= 1 && h <= 5) begin
      if (pre[h-1]) begin
        m_up[h-1] = 1'b0;
        if (m_score < CMAX) begin
          m_score++;
          sp = (m_score % 8 == 0);
        end
      end else begin
        m_miss = sat(m_miss);
      end
    end
    for (int i = 0; i < 5; i++)
      if (pre[i] && m_exp[i] == k && h != i + 1) begin
        m_up[i] = 1'b0;
        m_esc = sat(m_esc);
      end
    if (k == m_next_spawn) begin
      m_next_spawn = k + m_interval;
      idx = int'(pre_lfsr[2:0]) % 5;
      if (!pre[idx]) begin
        m_up[idx]  = 1'b1;
        m_exp[idx] = k + ML;
      end
    end
`ifdef MOLE_SPEEDUP_EN
    if (sp) begin
      m_interval = m_interval - m_interval / 8;
      if (m_interval < MI) m_interval = MI;
    end
`else
    if (sp) m_interval = SI;
`endif
  endtask

  task automatic compare_all();
    chk("moles",   32'(ifc.moles),       32'(m_up));
    chk("score",   32'(ifc.score),       32'(m_score));
    chk("misses",  32'(ifc.misses),      32'(m_miss));
    chk("escapes", 32'(ifc.escapes),     32'(m_esc));
    chk("active",  32'(ifc.game_active), 32'(m_state == 1));
    chk("over",    32'(ifc.game_over),   32'(m_state == 2));
  endtask

  task automatic step(input bit s, input int h, input bit r);
    ifc.start = s;
    ifc.hit   = 3'(h);
    reset     = r;
    @(posedge clock);
    model_edge(s, h, r);
    #1;
    compare_all();
  endtask

  function automatic int pick_hit();
    int roll;
    roll = int'($urandom_range(0, 99));
    if (m_state == 1) begin
      for (int i = 0; i < 5; i++)
        if (m_up[i] && m_exp[i] == k + 1 && roll < 50) return i + 1;
      if (m_up != '0 && roll < 70) begin
        for (int j = 0; j < 5; j++) begin
          int c;
          c = int'($urandom_range(0, 4));
          if (m_up[c]) return c + 1;
        end
      end
    end
    if (roll < 80) return 0;
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    int  hole;
    bit  found;
    ifc.start = 1'b0;
    ifc.hit   = 3'd0;
    m_lfsr = 8'h00;
    m_state = 0; m_up = '0; k = 0;
    m_score = 0; m_miss = 0; m_esc = 0;
    m_interval = SI; m_next_spawn = SI;
    for (int i = 0; i < 5; i++) m_exp[i] = -1;

    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, (i % 2) ? 3 : 0, 0);

    step(1, 0, 0);
    found = 1'b0;
    hole  = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      for (int j = 0; j < 5; j++)
        if (!found && m_up[j]) begin
          found = 1'b1;
          hole  = j;
        end
    end
    chk("first_spawn", 32'(found), 32'd1);
    step(0, 0, 0);
    step(0, hole + 1, 0);
    chk("first_hit_score", 32'(ifc.score), 32'd1);
    step(0, 7, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    for (int n = 0; n < 2500; n++) begin
      bit s, r;
      s = (m_state == 1) ? ($urandom_range(0, 29) == 0)
                         : ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 599) == 0);
      step(s, pick_hit(), r);
    end

    if (m_state != 1) step(1, 0, 0);
    for (int i = 0; i < GC + 2; i++) step(0, pick_hit(), 0);
    chk("round_over", 32'(ifc.game_over), 32'd1);
    step(1, 0, 0);
    chk("restart_score", 32'(ifc.score), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
